// File: rtl/debug_trace_buffer.sv
// Purpose: records each change of the debugger status word, stamped with a cycle count, in a circular trace FIFO.
// Latency: a capture is visible in count_o one cycle later; rd_en_i gives rd_vld_o/rd_data_o on the next cycle.
// Backpressure: none upstream. When the buffer is full, new events are dropped, or with TRACE_WRAP_EN they overwrite the oldest entry.
module debug_trace_buffer #(
  parameter int DATA_W = 32,
  parameter int TS_W   = 32,
  parameter int DEPTH  = 16,
  parameter int DROP_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_W-1:0]          evt_data_i,
  input  logic                       arm_i,
  input  logic                       stop_i,
  input  logic                       rd_en_i,
  output logic [TS_W+DATA_W-1:0]     rd_data_o,
  output logic                       rd_vld_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       overflow_o,
  output logic [DROP_W-1:0]          drop_cnt_o,
  output logic [1:0]                 state_o
);

  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = PW + 1;
  localparam int ENT_W = TS_W + DATA_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_FROZEN = 2'd2
  } state_t;

  state_t            state;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [TS_W-1:0]   ts;
  logic [DATA_W-1:0] last_word;
  logic              first_q;
  logic [ENT_W-1:0]  mem [DEPTH];

  logic armed;
  logic full;
  logic cap;
  logic rd_fire;
  logic wr_en;
  logic overwrite;
  logic drop;

  // Decode this cycle's capture, read, write and loss conditions.
  always_comb begin
    armed   = (state == ST_ARMED);
    full    = (count_o == CW'(DEPTH));
    // Arming flushes the buffer, so neither a capture nor a read may land in that cycle.
    cap     = armed && !arm_i && (first_q || (evt_data_i != last_word));
    rd_fire = rd_en_i && !arm_i && (count_o != '0);
    // A capture while full with no read to free a slot loses one event.
    drop    = cap && full && !rd_fire;
`ifdef TRACE_WRAP_EN
    wr_en     = cap;
    overwrite = drop;
`else
    wr_en     = cap && (!full || rd_fire);
    overwrite = 1'b0;
`endif
  end

  // Trace storage: not reset, since validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {ts, evt_data_i};
  end

  // Control FSM, pointers, timestamp, statistics and the registered read port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_o    <= '0;
      ts         <= '0;
      last_word  <= '0;
      first_q    <= 1'b0;
      overflow_o <= 1'b0;
      drop_cnt_o <= '0;
      rd_data_o  <= '0;
      rd_vld_o   <= 1'b0;
    end else begin
      rd_vld_o <= rd_fire;
      if (rd_fire) rd_data_o <= mem[rd_ptr];

      if (arm_i) begin
        // Arming wins over stop and starts a fresh capture from any state.
        state      <= ST_ARMED;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        count_o    <= '0;
        ts         <= '0;
        first_q    <= 1'b1;
        overflow_o <= 1'b0;
        drop_cnt_o <= '0;
      end else begin
        if (armed && stop_i) state <= ST_FROZEN;
        if (armed && (ts != '1)) ts <= ts + TS_W'(1);

        // last_word follows every capture, including dropped ones, so that one change yields exactly one drop.
        if (cap) begin
          last_word <= evt_data_i;
          first_q   <= 1'b0;
        end

        if (wr_en) wr_ptr <= wr_ptr + PW'(1);
        if (rd_fire || overwrite) rd_ptr <= rd_ptr + PW'(1);

        if (wr_en && !overwrite && !rd_fire) count_o <= count_o + CW'(1);
        else if (rd_fire && !wr_en)          count_o <= count_o - CW'(1);

        if (drop) begin
          overflow_o <= 1'b1;
          if (drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + DROP_W'(1);
        end
      end
    end
  end

  assign state_o = state;

endmodule
